// File: rtl/iccm_pkg.sv
// ---------------------------------------------------------------------------
// iccm_pkg
// Shared constants and types for the ICCM arbiter slice.
//   ICCM_ADDR_WIDTH / ICCM_DATA_WIDTH : default ICCM geometry (2048 x 32)
//   owner_e : which requester issued an outstanding read
//   state_e : boot/run FSM encoding
// ---------------------------------------------------------------------------
package iccm_pkg;

  localparam int ICCM_ADDR_WIDTH = 11;
  localparam int ICCM_DATA_WIDTH = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LD = 1'b1
  } owner_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/iccm_arbiter_if.sv
// ---------------------------------------------------------------------------
// iccm_arbiter_if
// Boundary bundle of the ICCM arbiter: fetch port, loader port, boot
// control and the ICCM controller request/return signals.
//   modport slave  : the arbiter's view
//   modport master : the surrounding system's view (requesters + controller)
// ---------------------------------------------------------------------------
interface iccm_arbiter_if
  import iccm_pkg::*;
#(
  parameter int ADDR_WIDTH = ICCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ICCM_DATA_WIDTH
);

  // fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  // loader port
  logic                  ld_req;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_gnt;
  logic                  ld_rvalid;
  logic [DATA_WIDTH-1:0] ld_rdata;
  // boot control
  logic                  boot_done;
  logic                  in_boot;
  // ICCM controller
  logic                  cntlr_rd;
  logic [ADDR_WIDTH-1:0] cntlr_raddr;
  logic                  cntlr_wr;
  logic [ADDR_WIDTH-1:0] cntlr_waddr;
  logic [DATA_WIDTH-1:0] cntlr_wr_data;
  logic [DATA_WIDTH-1:0] cntlr_rd_data;
  logic                  cntlr_rd_valid;

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, boot_done,
           cntlr_rd_data, cntlr_rd_valid,
    output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, in_boot,
           cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data
  );

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, boot_done,
           cntlr_rd_data, cntlr_rd_valid,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, in_boot,
           cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data
  );

endinterface

// File: rtl/iccm_rsp_router.sv
// ---------------------------------------------------------------------------
// iccm_rsp_router
// Tracks who issued each outstanding read and steers the controller's read
// return to that requester through one register stage.
//   clk, rst            : clock, async active-high reset
//   rd_grant_i          : a read was granted to the controller this cycle
//   rd_owner_i          : requester of that read
//   rd_valid_i/rd_data_i: controller read return
//   if_rvalid_o/if_rdata_o, ld_rvalid_o/ld_rdata_o : registered returns
// ---------------------------------------------------------------------------
module iccm_rsp_router
  import iccm_pkg::*;
#(
  parameter int DATA_WIDTH = ICCM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_grant_i,
  input  owner_e                rd_owner_i,
  input  logic                  rd_valid_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  ld_rvalid_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o
);

  // Two-entry in-order queue of owner bits; entry 0 is the oldest read.
  owner_e own_q [2];
  owner_e own_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] cnt_pop;
  logic       pop, push;
  logic       ret_if, ret_ld;

  logic                  if_rvalid_q, ld_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, ld_rdata_q;

  always_comb begin
    own_d[0] = own_q[0];
    own_d[1] = own_q[1];
    // A return with nothing outstanding (e.g. a read in flight across reset)
    // is dropped rather than routed to a stale owner.
    pop      = rd_valid_i && (cnt_q != 2'd0);
    cnt_pop  = cnt_q - {1'b0, pop};
    push     = rd_grant_i && (cnt_pop != 2'd2);
    if (pop) begin
      own_d[0] = own_q[1];
    end
    // New read lands right behind whatever is still outstanding after the pop.
    if (push) begin
      own_d[cnt_pop[0]] = rd_owner_i;
    end
    cnt_d  = cnt_pop + {1'b0, push};
    ret_if = pop && (own_q[0] == OWN_IF);
    ret_ld = pop && (own_q[0] == OWN_LD);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_own
    always_ff @(posedge clk or posedge rst) begin
      if (rst) own_q[gi] <= OWN_LD;
      else     own_q[gi] <= own_d[gi];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      if_rvalid_q <= ret_if;
      ld_rvalid_q <= ret_ld;
      if (ret_if) if_rdata_q <= rd_data_i;
      if (ret_ld) ld_rdata_q <= rd_data_i;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ld_rvalid_o = ld_rvalid_q;
  assign ld_rdata_o  = ld_rdata_q;

endmodule

// File: rtl/iccm_arbiter.sv
// ---------------------------------------------------------------------------
// iccm_arbiter
// Shares the ICCM controller port between instruction fetch (read-only) and
// the boot/debug loader (read/write). Fetch is held off until boot_done;
// afterwards the loader has priority, bounded by an anti-starvation counter.
//   clk, rst : clock, async active-high reset
//   bus      : iccm_arbiter_if.slave (fetch, loader, boot, controller ports)
// ---------------------------------------------------------------------------
module iccm_arbiter
  import iccm_pkg::*;
#(
  parameter int ADDR_WIDTH   = ICCM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = ICCM_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  iccm_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  logic                  if_gnt, ld_gnt;
  logic                  rd_grant;
  owner_e                rd_owner;
  logic                  cntlr_rd, cntlr_wr;
  logic [ADDR_WIDTH-1:0] cntlr_raddr, cntlr_waddr;
  logic [DATA_WIDTH-1:0] cntlr_wr_data;

  // FSM, grant and starvation next-state
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ld_gnt   = bus.ld_req;
        starve_d = 4'd0;
        if (bus.boot_done) state_d = ST_RUN;
      end
      default: begin
        if (bus.ld_req && bus.if_req) begin
          if (starve_q == LIMIT) if_gnt = 1'b1;
          else                   ld_gnt = 1'b1;
        end else begin
          ld_gnt = bus.ld_req;
          if_gnt = bus.if_req;
        end
        if (!bus.if_req || if_gnt) starve_d = 4'd0;
        else if (ld_gnt && starve_q < LIMIT) starve_d = starve_q + 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Controller drive straight from the granted request
  always_comb begin
    cntlr_rd      = 1'b0;
    cntlr_raddr   = '0;
    cntlr_wr      = 1'b0;
    cntlr_waddr   = '0;
    cntlr_wr_data = '0;
    if (if_gnt) begin
      cntlr_rd    = 1'b1;
      cntlr_raddr = bus.if_addr;
    end else if (ld_gnt && !bus.ld_we) begin
      cntlr_rd    = 1'b1;
      cntlr_raddr = bus.ld_addr;
    end else if (ld_gnt) begin
      cntlr_wr      = 1'b1;
      cntlr_waddr   = bus.ld_addr;
      cntlr_wr_data = bus.ld_wdata;
    end
  end

  assign rd_grant = cntlr_rd;
  assign rd_owner = if_gnt ? OWN_IF : OWN_LD;

  iccm_rsp_router #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_router (
    .clk         (clk),
    .rst         (rst),
    .rd_grant_i  (rd_grant),
    .rd_owner_i  (rd_owner),
    .rd_valid_i  (bus.cntlr_rd_valid),
    .rd_data_i   (bus.cntlr_rd_data),
    .if_rvalid_o (bus.if_rvalid),
    .if_rdata_o  (bus.if_rdata),
    .ld_rvalid_o (bus.ld_rvalid),
    .ld_rdata_o  (bus.ld_rdata)
  );

  assign bus.if_gnt        = if_gnt;
  assign bus.ld_gnt        = ld_gnt;
  assign bus.in_boot       = (state_q == ST_BOOT);
  assign bus.cntlr_rd      = cntlr_rd;
  assign bus.cntlr_raddr   = cntlr_raddr;
  assign bus.cntlr_wr      = cntlr_wr;
  assign bus.cntlr_waddr   = cntlr_waddr;
  assign bus.cntlr_wr_data = cntlr_wr_data;

endmodule

// File: tb/tb_iccm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iccm_arbiter
// Directed bench for iccm_arbiter with a 1-cycle ICCM model that returns
// (read address + 0x100). Inputs change 1 time unit after posedge; outputs
// are checked 4 time units after posedge.
// ---------------------------------------------------------------------------
module tb_iccm_arbiter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  iccm_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

  iccm_arbiter #(
    .ADDR_WIDTH   (11),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ICCM controller model: read data one cycle after the read strobe
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cntlr_rd_valid <= 1'b0;
      bus.cntlr_rd_data  <= 32'h0;
    end else begin
      bus.cntlr_rd_valid <= bus.cntlr_rd;
      if (bus.cntlr_rd) bus.cntlr_rd_data <= 32'(bus.cntlr_raddr) + 32'h100;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total       = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_wdata  = '0;
    bus.boot_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    check("rst_in_boot",   32'(bus.in_boot),   32'd1);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
    check("rst_if_rdata",  bus.if_rdata,       32'h0);
    check("rst_ld_rdata",  bus.ld_rdata,       32'h0);
    check("rst_cntlr_rd",  32'(bus.cntlr_rd),  32'd0);
    check("rst_cntlr_wr",  32'(bus.cntlr_wr),  32'd0);

    // BOOT: loader write wins even with fetch asking
    tick();
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 11'h7FF;
    bus.ld_wdata = 32'hDEADBEEF;
    bus.if_req   = 1'b1;
    bus.if_addr  = 11'h010;
    settle();
    check("boot_ld_gnt",   32'(bus.ld_gnt),     32'd1);
    check("boot_if_gnt",   32'(bus.if_gnt),     32'd0);
    check("boot_wr",       32'(bus.cntlr_wr),   32'd1);
    check("boot_waddr",    32'(bus.cntlr_waddr), 32'h7FF);
    check("boot_wdata",    bus.cntlr_wr_data,   32'hDEADBEEF);
    check("boot_rd",       32'(bus.cntlr_rd),   32'd0);
    tick();
    bus.ld_req = 1'b0;
    bus.ld_we  = 1'b0;

    // BOOT: fetch held off for 5 cycles, and the write produces no rvalid
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("hold_if_gnt_%0d", i),    32'(bus.if_gnt),    32'd0);
      check($sformatf("hold_in_boot_%0d", i),   32'(bus.in_boot),   32'd1);
      check($sformatf("hold_if_rvalid_%0d", i), 32'(bus.if_rvalid), 32'd0);
      check($sformatf("hold_ld_rvalid_%0d", i), 32'(bus.ld_rvalid), 32'd0);
      tick();
    end

    // boot_done cycle: still BOOT, fetch still blocked
    bus.boot_done = 1'b1;
    settle();
    check("done_cyc_if_gnt", 32'(bus.if_gnt), 32'd0);
    tick();
    bus.boot_done = 1'b0;
    settle();
    check("run_in_boot",  32'(bus.in_boot),     32'd0);
    check("run_if_gnt",   32'(bus.if_gnt),      32'd1);
    check("run_cntlr_rd", 32'(bus.cntlr_rd),    32'd1);
    check("run_raddr",    32'(bus.cntlr_raddr), 32'h010);
    tick();
    bus.if_req = 1'b0;
    settle();
    check("lat1_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();
    settle();
    check("lat2_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("lat2_if_rdata",  bus.if_rdata,       32'h110);
    check("lat2_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
    tick();
    settle();
    check("lat3_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();

    // Starvation: both held, pattern LD x4 then IF; boot_done in RUN ignored
    bus.if_req   = 1'b1;
    bus.if_addr  = 11'h030;
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 11'h040;
    for (int i = 0; i < 10; i++) begin
      bus.ld_wdata  = 32'(i);
      bus.boot_done = (i == 2);
      settle();
      check($sformatf("starve_ld_gnt_%0d", i), 32'(bus.ld_gnt), 32'((i % 5) != 4));
      check($sformatf("starve_if_gnt_%0d", i), 32'(bus.if_gnt), 32'((i % 5) == 4));
      check($sformatf("starve_in_boot_%0d", i), 32'(bus.in_boot), 32'd0);
      tick();
    end
    bus.boot_done = 1'b0;
    bus.if_req    = 1'b0;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    repeat (3) tick();

    // Alternating reads IF@004, LD@008, IF@00C
    bus.if_req  = 1'b1;
    bus.if_addr = 11'h004;
    settle();
    check("alt0_if_gnt", 32'(bus.if_gnt),      32'd1);
    check("alt0_raddr",  32'(bus.cntlr_raddr), 32'h004);
    tick();
    bus.if_req  = 1'b0;
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 11'h008;
    settle();
    check("alt1_ld_gnt",    32'(bus.ld_gnt),      32'd1);
    check("alt1_cntlr_rd",  32'(bus.cntlr_rd),    32'd1);
    check("alt1_raddr",     32'(bus.cntlr_raddr), 32'h008);
    check("alt1_if_rvalid", 32'(bus.if_rvalid),   32'd0);
    tick();
    bus.ld_req  = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 11'h00C;
    settle();
    check("alt2_raddr",     32'(bus.cntlr_raddr), 32'h00C);
    check("alt2_if_rvalid", 32'(bus.if_rvalid),   32'd1);
    check("alt2_if_rdata",  bus.if_rdata,         32'h104);
    check("alt2_ld_rvalid", 32'(bus.ld_rvalid),   32'd0);
    tick();
    bus.if_req = 1'b0;
    settle();
    check("alt3_ld_rvalid", 32'(bus.ld_rvalid), 32'd1);
    check("alt3_ld_rdata",  bus.ld_rdata,       32'h108);
    check("alt3_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();
    settle();
    check("alt4_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("alt4_if_rdata",  bus.if_rdata,       32'h10C);
    check("alt4_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
    tick();
    settle();
    check("alt5_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("alt5_ld_rdata_hold", bus.ld_rdata,   32'h108);
    tick();

    // Reset one cycle after a fetch read grant
    bus.if_req  = 1'b1;
    bus.if_addr = 11'h020;
    settle();
    check("rstop_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick();
    bus.if_req = 1'b0;
    rst        = 1'b1;
    settle();
    check("rstop_in_boot",   32'(bus.in_boot),   32'd1);
    check("rstop_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rstop_if_rdata",  bus.if_rdata,       32'h0);
    check("rstop_ld_rdata",  bus.ld_rdata,       32'h0);
    check("rstop_cntlr_rd",  32'(bus.cntlr_rd),  32'd0);
    tick();
    settle();
    check("rstop2_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("rstop3_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rstop3_in_boot",   32'(bus.in_boot),   32'd1);
    tick();
    settle();
    check("rstop4_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rstop4_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iccm_arbiter.md
Name: iccm_arbiter

Overview:
- Shares the single ICCM controller port between two requesters: instruction fetch (read-only) and the boot/debug loader (read and write).
- Sits between the core front-end/loader and the ICCM controller. It drives the controller's cntlr_* request signals and routes the 1-cycle read return back to the requester that issued the read.
- Holds fetch off during boot until the loader signals completion. After that, it arbitrates with loader priority, bounded by an anti-starvation counter.

Parameters:
- ADDR_WIDTH, 11, ICCM word-address width (2048 words).
- DATA_WIDTH, 32, ICCM data width.
- STARVE_LIMIT, 4, maximum consecutive loader grants while fetch is waiting; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- ld_req  in  1  loader request
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_WIDTH  loader word address
- ld_wdata  in  DATA_WIDTH  loader write data
- ld_gnt  out  1  loader request accepted this cycle (combinational)
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_WIDTH  loader read data
- boot_done  in  1  single-cycle pulse: image loaded, release fetch
- in_boot  out  1  1 while the FSM is in BOOT
- cntlr_rd  out  1  read strobe to ICCM controller
- cntlr_raddr  out  ADDR_WIDTH  read address
- cntlr_wr  out  1  write strobe
- cntlr_waddr  out  ADDR_WIDTH  write address
- cntlr_wr_data  out  DATA_WIDTH  write data
- cntlr_rd_data  in  DATA_WIDTH  read data, valid with cntlr_rd_valid
- cntlr_rd_valid  in  1  read return, 1 cycle after cntlr_rd

Behaviour:
- Reset values:
  - FSM = BOOT; in_boot = 1; starvation counter = 0; read-owner flag = LD.
  - if_rvalid, ld_rvalid = 0; if_rdata, ld_rdata = 0.
- FSM:
  - BOOT: only the loader can be granted; if_gnt = 0 regardless of if_req. BOOT->RUN on boot_done = 1.
  - RUN: normal arbitration. RUN is terminal until rst.
  - boot_done in RUN is ignored.
- Grant, RUN state, computed each cycle:
  - Only ld_req: ld_gnt = 1.
  - Only if_req: if_gnt = 1.
  - Both asserted: ld_gnt = 1, unless the starvation counter equals STARVE_LIMIT; in that case if_gnt = 1.
  - At most one grant per cycle. No grant when neither requester is asserted.
  - During the boot_done cycle the FSM is still BOOT, so the loader still wins.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when ld_gnt is given while if_req = 1.
  - Clears on any if_gnt, or on any cycle with if_req = 0.
  - Frozen at 0 in BOOT.
- Controller drive, purely combinational from the granted request:
  - Fetch grant: cntlr_rd = 1, cntlr_raddr = if_addr.
  - Loader read grant: cntlr_rd = 1, cntlr_raddr = ld_addr.
  - Loader write grant: cntlr_wr = 1, cntlr_waddr = ld_addr, cntlr_wr_data = ld_wdata.
  - Unused outputs are driven to 0. cntlr_rd and cntlr_wr are never both 1.
- Read-owner flag:
  - Registered on every granted read: IF or LD.
  - On cntlr_rd_valid = 1, cntlr_rd_data is routed to the owner's rdata, and that rvalid = 1 for exactly one cycle, registered.
  - The other rvalid stays 0. rdata holds its last value when rvalid = 0.
- Latency:
  - Grant to the controller is in the same cycle as the request.
  - rvalid = cntlr_rd_valid + 1 register stage, i.e. 2 cycles after grant for a 1-cycle controller.
- Back-to-back reads:
  - The owner flag must be pipelined to match the controller latency: a 2-entry shift of owner bits, indexed by return.
  - Alternating IF/LD reads every cycle must each return to the correct requester in order.
- Writes produce no rvalid.
- A request is held by the requester until granted. Changing address while waiting is legal; the address sampled at grant is the one used.
- rst mid-operation: outstanding read returns are discarded, no rvalid, and the FSM returns to BOOT.

Decomposition:
- Shared package iccm_pkg:
  - ICCM_ADDR_WIDTH and ICCM_DATA_WIDTH constants.
  - Owner enum {OWN_IF, OWN_LD}.
  - Boot FSM enum {ST_BOOT, ST_RUN}.
- One sub-module, iccm_rsp_router: owner-bit shift pipeline plus the rvalid/rdata output registers.
- Grant logic, starvation counter and FSM stay in the top.

Test Plan:
- Reset, then if_req = 1 with if_addr = 0x010 for 5 cycles -> if_gnt = 0 throughout, in_boot = 1. After a boot_done pulse: if_gnt = 1 on the next cycle, cntlr_rd = 1, cntlr_raddr = 0x010.
- BOOT: ld write addr 0x7FF, data 0xDEADBEEF -> cntlr_wr = 1, cntlr_waddr = 0x7FF, cntlr_wr_data = 0xDEADBEEF the same cycle; no rvalid follows.
- RUN: if_req and ld_req both held continuously, STARVE_LIMIT = 4 -> grant pattern LD, LD, LD, LD, IF, repeating.
- RUN: alternating grants IF@0x004, LD@0x008, IF@0x00C with a memory model returning addr+0x100 -> if_rdata = 0x104, then ld_rdata = 0x108, then if_rdata = 0x10C, each rvalid one cycle wide on the correct port only.
- Assert rst one cycle after a fetch read grant -> no if_rvalid, in_boot = 1, all outputs at reset values.
- boot_done pulsed in RUN while requests are active -> no change to grant pattern or FSM.
